// File: rtl/mult_block_pkg.sv
// Shared types and the operand-extending multiply used by the multiply-to-memory engine.
package mult_block_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        READ = 2'd2
    } mbe_state_t;

    localparam int MBE_OPND_MAX = 64;
    localparam int MBE_PROD_MAX = 128;

    // Extends each inW-bit operand (sign or zero), multiplies, and keeps the low width bits.
    function automatic logic [MBE_PROD_MAX-1:0] mbe_ext_product(
        input logic [MBE_OPND_MAX-1:0] a,
        input logic [MBE_OPND_MAX-1:0] b,
        input logic                    isSigned,
        input int                      width,
        input int                      inW
    );
        logic signed [MBE_PROD_MAX-1:0] ea;
        logic signed [MBE_PROD_MAX-1:0] eb;
        logic signed [MBE_PROD_MAX-1:0] prod;
        logic        [MBE_PROD_MAX-1:0] mask;
        int                             sh;
        sh = MBE_PROD_MAX - inW;
        ea = {{MBE_OPND_MAX{1'b0}}, a};
        eb = {{MBE_OPND_MAX{1'b0}}, b};
        if (isSigned) begin
            ea = (ea << sh) >>> sh;
            eb = (eb << sh) >>> sh;
        end else begin
            ea = (ea << sh) >> sh;
            eb = (eb << sh) >> sh;
        end
        prod = ea * eb;
        mask = (width >= MBE_PROD_MAX) ? '1
             : ((MBE_PROD_MAX'(1) << width) - MBE_PROD_MAX'(1));
        return prod & mask;
    endfunction

endpackage

// File: rtl/mult_out_skid.sv
// Two-entry valid/ready FIFO for returned read data; exposes occupancy to the read issuer.
module mult_out_skid
    import mult_block_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    output logic             popValid,
    input  logic             popReady,
    output logic [WIDTH-1:0] popData,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slots [2];
    logic             rdPtr;
    logic             wrPtr;
    logic             popFire;

    assign popValid = (count != 2'd0);
    assign popFire  = popValid && popReady;
    assign popData  = popValid ? slots[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pushValid) wrPtr <= ~wrPtr;
            if (popFire)   rdPtr <= ~rdPtr;
            case ({pushValid, popFire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: data slots carry no reset; the output is gated by popValid, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (pushValid) slots[wrPtr] <= pushData;
    end

endmodule

// File: rtl/mult_block_engine.sv
// Multiplies operand pairs into consecutive memory entries (port B) and streams the
// block back out through port A and a 2-entry skid with a valid/ready handshake.
module mult_block_engine
    import mult_block_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN_mult,
    output logic             RDY_mult,
    input  logic [IN_W-1:0]  mult_input0,
    input  logic [IN_W-1:0]  mult_input1,
    input  logic             mult_signed,
    input  logic             acc_mode,
    output logic             EN_writeMem,
    output logic [AW-1:0]    writeMem_addr,
    output logic [WIDTH-1:0] writeMem_val,
    input  logic             EN_blockRead,
    output logic             EN_readMem,
    output logic [AW-1:0]    readMem_addr,
    input  logic [WIDTH-1:0] readMem_val,
    output logic             VALID_memVal,
    input  logic             memVal_ready,
    output logic [WIDTH-1:0] memVal_data,
    output logic [AW:0]      block_len
);

    // Running sums are allowed to wrap, so only the plain product must fit in WIDTH.
    if (IN_W < 1 || IN_W > MBE_OPND_MAX) begin : gBadInW
        $error("mult_block_engine: IN_W out of range");
    end
    if (WIDTH < 2 * IN_W || WIDTH > MBE_PROD_MAX) begin : gBadWidth
        $error("mult_block_engine: WIDTH out of range");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW != $clog2(DEPTH)) begin : gBadDepth
        $error("mult_block_engine: DEPTH must be a power of two >= 2 with AW derived");
    end

    localparam logic [AW:0]   LAST_LEN = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    mbe_state_t       state;
    logic [AW-1:0]    wrAddr;
    logic [AW:0]      rdIssued;
    logic [WIDTH-1:0] acc;
    logic             accHold;
    logic             readPending;

    logic             accept;
    logic             effAcc;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] result;
    logic [1:0]       skidCount;
    logic [1:0]       occAfterPop;
    logic             popFire;
    logic             rdHazard;
    logic             lastXfer;

    assign accept  = EN_mult && RDY_mult;
    assign effAcc  = (block_len == '0) ? acc_mode : accHold;
    assign product = WIDTH'(mbe_ext_product(MBE_OPND_MAX'(mult_input0), MBE_OPND_MAX'(mult_input1),
                                            mult_signed, WIDTH, IN_W));
    assign result  = effAcc ? (acc + product) : product;

    // Issue only if everything already committed still fits in the skid should the consumer stall.
    assign popFire      = VALID_memVal && memVal_ready;
    assign occAfterPop  = skidCount + {1'b0, readPending} - {1'b0, popFire};
    assign rdHazard     = EN_writeMem && (writeMem_addr == rdIssued[AW-1:0]);
    assign EN_readMem   = (state == READ) && (rdIssued != block_len)
                       && (occAfterPop < 2'd2) && !rdHazard;
    assign readMem_addr = rdIssued[AW-1:0];
    assign lastXfer     = (state == READ) && popFire && (skidCount == 2'd1)
                       && !readPending && (rdIssued == block_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            RDY_mult      <= 1'b0;
            wrAddr        <= '0;
            rdIssued      <= '0;
            block_len     <= '0;
            acc           <= '0;
            accHold       <= 1'b0;
            readPending   <= 1'b0;
            EN_writeMem   <= 1'b0;
            writeMem_addr <= '0;
            writeMem_val  <= '0;
        end else begin
            EN_writeMem <= accept;
            readPending <= EN_readMem;
            if (EN_readMem) rdIssued <= rdIssued + LEN_ONE;
            if (accept) begin
                writeMem_addr <= wrAddr;
                writeMem_val  <= result;
                wrAddr        <= wrAddr + ADDR_ONE;
                block_len     <= block_len + LEN_ONE;
                if (effAcc) acc <= result;
                if (block_len == '0) accHold <= acc_mode;
            end
            case (state)
                FILL: begin
                    // NOTE: a later non-blocking assignment to the same register in this block wins.
                    RDY_mult <= 1'b1;
                    if (EN_blockRead && (block_len != '0 || accept)) begin
                        state    <= READ;
                        RDY_mult <= 1'b0;
                    end else if (accept && block_len == LAST_LEN) begin
                        state    <= FULL;
                        RDY_mult <= 1'b0;
                    end
                end
                FULL: begin
                    if (EN_blockRead) state <= READ;
                end
                READ: begin
                    if (lastXfer) begin
                        state     <= FILL;
                        RDY_mult  <= 1'b1;
                        wrAddr    <= '0;
                        rdIssued  <= '0;
                        block_len <= '0;
                        acc       <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    mult_out_skid #(.WIDTH(WIDTH)) skid (
        .clk      (clk),
        .rst      (rst),
        .pushValid(readPending),
        .pushData (readMem_val),
        .popValid (VALID_memVal),
        .popReady (memVal_ready),
        .popData  (memVal_data),
        .count    (skidCount)
    );

endmodule
